// File: rtl/param_seq_detector.sv
// rtl/param_seq_detector.sv - programmable serial bit-sequence detector with saturating match counter
// Reset configuration is the non-overlapping "001" detector.
module param_seq_detector #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               inp_valid,
  input  logic               inp,
  input  logic               count_clr,
  output logic               det,
  output logic [CNT_W-1:0]   match_count,
  output logic               count_sat
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               det_q, det_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               accept;
  logic [MAX_LEN-1:0] hist_shift;
  logic [LEN_W-1:0]   fill_inc;
  logic [MAX_LEN-1:0] len_mask;
  logic               match;

  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q  <= MAX_LEN'(3'b001);
      len_q  <= LEN_W'(3);
      ovl_q  <= 1'b0;
      hist_q <= '0;
      fill_q <= '0;
      det_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pat_q  <= pat_d;
      len_q  <= len_d;
      ovl_q  <= ovl_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      det_q  <= det_d;
      cnt_q  <= cnt_d;
    end
  end

  // Match is judged on the history as it will look after this sample.
  always_comb begin
    accept     = inp_valid & ~cfg_load;
    hist_shift = {hist_q[MAX_LEN-2:0], inp};
    fill_inc   = (fill_q == LEN_MAX) ? fill_q : fill_q + 1'b1;
    len_mask   = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < int'(len_q));
    end
    match = accept && (len_q != '0) && (fill_inc >= len_q) &&
            (((hist_shift ^ pat_q) & len_mask) == '0);
  end

  always_comb begin
    pat_d  = pat_q;
    len_d  = len_q;
    ovl_d  = ovl_q;
    hist_d = hist_q;
    fill_d = fill_q;
    det_d  = match;
    cnt_d  = cnt_q;
    if (cfg_load) begin
      pat_d  = cfg_pattern;
      len_d  = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
      ovl_d  = cfg_overlap;
      hist_d = '0;
      fill_d = '0;
    end else if (accept) begin
      hist_d = hist_shift;
      // Non-overlapping mode restarts the fill so no matched bit is reused.
      fill_d = (match && !ovl_q) ? '0 : fill_inc;
    end
    if (count_clr) begin
      cnt_d = '0;
    end else if (match && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    det         = det_q;
    match_count = cnt_q;
    count_sat   = (cnt_q == CNT_MAX);
  end

endmodule
